conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 149 ++++++++++++++
 tb/tb_conv_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for a convolution datapath built from ring counters.
// Each start clears the ring counters, then for NUM_ROWS rows writes 9 words per row;
// each word takes 24 kernel/pixel stepping cycles followed by one memory write cycle.
// Optional feature macro SEQ_STALL_EN: when defined, RUN only progresses in cycles
// with pix_valid_s1 high; when undefined, pix_valid_s1 is ignored.
module conv_sequencer #(
    parameter int NUM_ROWS = 4
) (
    input  logic Phi1,
    input  logic Reset_s1,
    input  logic start_s1,
    input  logic pix_valid_s1,
    output logic step_c3_s1,
    output logic step_c8_s1,
    output logic step_c9_s1,
    output logic step_p3_s1,
    output logic ctr_reset_s1,
    output logic mem_we_s1,
    output logic busy_s1,
    output logic done_s1
);

    localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] kcnt;
    logic [1:0] kcnt_nxt;
    logic [2:0] pcnt;
    logic [2:0] pcnt_nxt;
    logic [3:0] wcnt;
    logic [3:0] wcnt_nxt;
    logic [7:0] rcnt;
    logic [7:0] rcnt_nxt;
    logic       progress;

`ifdef SEQ_STALL_EN
    assign progress = pix_valid_s1;
`else
    logic unused_pix_valid;
    assign unused_pix_valid = pix_valid_s1;
    assign progress         = 1'b1;
`endif

    // State and counter registers; reset returns to IDLE with all counters cleared.
    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            state <= S_IDLE;
            kcnt  <= 2'd0;
            pcnt  <= 3'd0;
            wcnt  <= 4'd0;
            rcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            kcnt  <= kcnt_nxt;
            pcnt  <= pcnt_nxt;
            wcnt  <= wcnt_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Next-state, counter updates and strobe decode from the current state and counters.
    always_comb begin
        state_nxt    = state;
        kcnt_nxt     = kcnt;
        pcnt_nxt     = pcnt;
        wcnt_nxt     = wcnt;
        rcnt_nxt     = rcnt;
        step_c3_s1   = 1'b0;
        step_c8_s1   = 1'b0;
        step_c9_s1   = 1'b0;
        step_p3_s1   = 1'b0;
        ctr_reset_s1 = 1'b0;
        mem_we_s1    = 1'b0;
        done_s1      = 1'b0;
        busy_s1      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start_s1) begin
                    state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                ctr_reset_s1 = 1'b1;
                kcnt_nxt     = 2'd0;
                pcnt_nxt     = 3'd0;
                wcnt_nxt     = 4'd0;
                rcnt_nxt     = 8'd0;
                state_nxt    = S_RUN;
            end

            S_RUN: begin
                if (progress) begin
                    step_c3_s1 = 1'b1;
                    if (kcnt == 2'd2) begin
                        kcnt_nxt   = 2'd0;
                        step_c8_s1 = 1'b1;
                        if (pcnt == 3'd7) begin
                            pcnt_nxt  = 3'd0;
                            state_nxt = S_WRITE;
                        end else begin
                            pcnt_nxt = pcnt + 3'd1;
                        end
                    end else begin
                        kcnt_nxt = kcnt + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                mem_we_s1  = 1'b1;
                step_c9_s1 = 1'b1;
                if (wcnt == 4'd8) begin
                    wcnt_nxt   = 4'd0;
                    step_p3_s1 = 1'b1;
                    if (rcnt == LAST_ROW) begin
                        state_nxt = S_DONE;
                    end else begin
                        rcnt_nxt  = rcnt + 8'd1;
                        state_nxt = S_RUN;
                    end
                end else begin
                    wcnt_nxt  = wcnt + 4'd1;
                    state_nxt = S_RUN;
                end
            end

            S_DONE: begin
                done_s1   = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: self-checking bench for conv_sequencer.
// The reference model treats a pass as a linear list of slots (CLR, NR*225 work slots,
// DONE) and derives every strobe from the slot index with plain arithmetic.
module tb_conv_sequencer;

    localparam int NR        = 3;
    localparam int DONE_SLOT = NR * 225 + 1;
`ifdef SEQ_STALL_EN
    localparam int STALL_SHIFT = 5;
`else
    localparam int STALL_SHIFT = 0;
`endif

    logic Phi1 = 1'b0;
    logic Reset_s1 = 1'b0;
    logic start_s1 = 1'b0;
    logic pix_valid_s1 = 1'b0;
    logic step_c3_s1, step_c8_s1, step_c9_s1, step_p3_s1;
    logic ctr_reset_s1, mem_we_s1, busy_s1, done_s1;

    conv_sequencer #(.NUM_ROWS(NR)) dut (
        .Phi1(Phi1),
        .Reset_s1(Reset_s1),
        .start_s1(start_s1),
        .pix_valid_s1(pix_valid_s1),
        .step_c3_s1(step_c3_s1),
        .step_c8_s1(step_c8_s1),
        .step_c9_s1(step_c9_s1),
        .step_p3_s1(step_p3_s1),
        .ctr_reset_s1(ctr_reset_s1),
        .mem_we_s1(mem_we_s1),
        .busy_s1(busy_s1),
        .done_s1(done_s1)
    );

    always #5 Phi1 = ~Phi1;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] obs_vec;
    logic [7:0] exp_vec;
    logic       m_active = 1'b0;
    int         m_slot = 0;

    // Bit order: ctr_reset, c3, c8, c9, p3, we, busy, done
    function automatic logic prog(input logic pv);
`ifdef SEQ_STALL_EN
        return pv;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic is_run(input int slot);
        return (slot >= 1) && (slot <= NR * 225) && (((slot - 1) % 25) < 24);
    endfunction

    function automatic logic [7:0] model_out(input logic active, input int slot, input logic pv);
        logic [7:0] v;
        int u;
        v = 8'h00;
        if (active) begin
            v[1] = 1'b1;
            if (slot == 0) begin
                v[7] = 1'b1;
            end else if (slot == DONE_SLOT) begin
                v[0] = 1'b1;
            end else begin
                u = slot - 1;
                if ((u % 25) < 24) begin
                    if (prog(pv)) begin
                        v[6] = 1'b1;
                        if (((u % 25) % 3) == 2) v[5] = 1'b1;
                    end
                end else begin
                    v[2] = 1'b1;
                    v[4] = 1'b1;
                    if (((u / 25) % 9) == 8) v[3] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    // One clock cycle: drive inputs, capture DUT and model outputs, then advance the model.
    task automatic step(input logic st, input logic pv, input logic rs);
        @(negedge Phi1);
        start_s1     = st;
        pix_valid_s1 = pv;
        Reset_s1     = rs;
        #1;
        obs_vec = {ctr_reset_s1, step_c3_s1, step_c8_s1, step_c9_s1,
                   step_p3_s1, mem_we_s1, busy_s1, done_s1};
        exp_vec = model_out(m_active, m_slot, pv);
        if (rs) begin
            m_active = 1'b0;
            m_slot   = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_slot   = 0;
            end
        end else if (m_slot == DONE_SLOT) begin
            m_active = 1'b0;
        end else if (!(is_run(m_slot) && !prog(pv))) begin
            m_slot = m_slot + 1;
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs_vec, 8'h00);
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_vec !== 8'h00) begin
            failures++;
            $display("FAIL reset_over_start got=%b exp=%b", obs_vec, 8'h00);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_vec !== 8'h00) begin
            failures++;
            $display("FAIL reset_stays_idle got=%b exp=%b", obs_vec, 8'h00);
        end
    endtask

    task automatic test_single_pass();
        int n_c3, n_c8, n_c9, n_p3, n_we, n_clr;
        int first_we, first_c8, done_cyc, clr_cyc, busy_first, busy_last;
        n_c3 = 0; n_c8 = 0; n_c9 = 0; n_p3 = 0; n_we = 0; n_clr = 0;
        first_we = -1; first_c8 = -1; done_cyc = -1; clr_cyc = -1;
        busy_first = -1; busy_last = -1;
        for (int t = 0; t <= DONE_SLOT + 4; t++) begin
            step(t == 0, 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL single_pass_cycle cyc=%0d got=%b exp=%b", t, obs_vec, exp_vec);
            end
            if (obs_vec[7]) begin n_clr++; clr_cyc = t; end
            if (obs_vec[6]) n_c3++;
            if (obs_vec[5]) begin n_c8++; if (first_c8 < 0) first_c8 = t; end
            if (obs_vec[4]) n_c9++;
            if (obs_vec[3]) n_p3++;
            if (obs_vec[2]) begin n_we++; if (first_we < 0) first_we = t; end
            if (obs_vec[1]) begin if (busy_first < 0) busy_first = t; busy_last = t; end
            if (obs_vec[0]) done_cyc = t;
        end
        checks++;
        if (n_clr !== 1 || clr_cyc !== 1) begin
            failures++;
            $display("FAIL clr_cycle got=%0d@%0d exp=1@1", n_clr, clr_cyc);
        end
        checks++;
        if (n_c3 !== NR * 216) begin
            failures++;
            $display("FAIL c3_total got=%0d exp=%0d", n_c3, NR * 216);
        end
        checks++;
        if (n_c8 !== NR * 72 || first_c8 !== 4) begin
            failures++;
            $display("FAIL c8_total got=%0d first=%0d exp=%0d first=4", n_c8, first_c8, NR * 72);
        end
        checks++;
        if (n_c9 !== NR * 9 || n_we !== NR * 9) begin
            failures++;
            $display("FAIL c9_we_total got=%0d/%0d exp=%0d", n_c9, n_we, NR * 9);
        end
        checks++;
        if (n_p3 !== NR) begin
            failures++;
            $display("FAIL p3_total got=%0d exp=%0d", n_p3, NR);
        end
        checks++;
        if (first_we !== 26) begin
            failures++;
            $display("FAIL first_write got=%0d exp=26", first_we);
        end
        checks++;
        if (done_cyc !== 1 + NR * 225 + 1) begin
            failures++;
            $display("FAIL done_cycle got=%0d exp=%0d", done_cyc, 1 + NR * 225 + 1);
        end
        checks++;
        if (busy_first !== 1 || busy_last !== 1 + NR * 225 + 1) begin
            failures++;
            $display("FAIL busy_window got=%0d..%0d exp=1..%0d", busy_first, busy_last, 1 + NR * 225 + 1);
        end
    endtask

    task automatic test_start_ignored();
        int n_clr, n_done;
        n_clr = 0; n_done = 0;
        for (int t = 0; t <= DONE_SLOT + 5; t++) begin
            step((t == 0) || (t == 50) || (t == DONE_SLOT + 1), 1'b1, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL start_ignored_cycle cyc=%0d got=%b exp=%b", t, obs_vec, exp_vec);
            end
            if (obs_vec[7]) n_clr++;
            if (obs_vec[0]) n_done++;
        end
        checks++;
        if (n_clr !== 1 || n_done !== 1) begin
            failures++;
            $display("FAIL start_ignored_counts got=clr%0d/done%0d exp=clr1/done1", n_clr, n_done);
        end
    endtask

    task automatic test_stall_window();
        int first_we;
        first_we = -1;
        for (int t = 0; t <= 40; t++) begin
            step(t == 0, !(t >= 10 && t <= 14), 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL stall_cycle cyc=%0d got=%b exp=%b", t, obs_vec, exp_vec);
            end
            if (obs_vec[2] && first_we < 0) first_we = t;
        end
        checks++;
        if (first_we !== 26 + STALL_SHIFT) begin
            failures++;
            $display("FAIL stall_first_write got=%0d exp=%0d", first_we, 26 + STALL_SHIFT);
        end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_mid_pass_reset();
        int n_done, n;
        n_done = 0;
        for (int t = 0; t <= 110; t++) begin
            step(t == 0, 1'b1, t == 100);
            if (obs_vec[0]) n_done++;
            if (t == 101) begin
                checks++;
                if (obs_vec !== 8'h00) begin
                    failures++;
                    $display("FAIL abort_idle got=%b exp=%b", obs_vec, 8'h00);
                end
            end
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", n_done);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_vec[7] !== 1'b1) begin
            failures++;
            $display("FAIL restart_clr got=%b exp=1", obs_vec[7]);
        end
        n = 0;
        while (m_active && n < 2000) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL restart_cycle n=%0d got=%b exp=%b", n, obs_vec, exp_vec);
            end
        end
        checks++;
        if (m_active) begin
            failures++;
            $display("FAIL restart_timeout got=active exp=idle");
        end
    endtask

    task automatic test_random_stall();
        int n, rst_at;
        for (int p = 0; p < 3; p++) begin
            rst_at = (p == 1) ? int'($urandom_range(20, 400)) : -1;
            step(1'b1, 1'b1, 1'b0);
            n = 0;
            while (m_active && n < 4000) begin
                step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, n == rst_at);
                n++;
                checks++;
                if (obs_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL random_cycle pass=%0d n=%0d got=%b exp=%b", p, n, obs_vec, exp_vec);
                end
            end
            checks++;
            if (m_active) begin
                failures++;
                $display("FAIL random_timeout pass=%0d got=active exp=idle", p);
            end
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int n_clr, n_done, n, starts;
        n_clr = 0; n_done = 0; n = 0; starts = 0;
        while (n < 2 * (DONE_SLOT + 4)) begin
            step(!m_active && starts < 2, 1'b1, 1'b0);
            if (start_s1) starts++;
            n++;
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL b2b_cycle n=%0d got=%b exp=%b", n, obs_vec, exp_vec);
            end
            if (obs_vec[7]) n_clr++;
            if (obs_vec[0]) n_done++;
        end
        checks++;
        if (n_clr !== 2 || n_done !== 2) begin
            failures++;
            $display("FAIL b2b_counts got=clr%0d/done%0d exp=clr2/done2", n_clr, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_start_ignored();
        test_stall_window();
        test_mid_pass_reset();
        test_random_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
